// File: rtl/wb_stage.sv
// wb_stage: write-back stage driving the register-file write port.
// Selects between the ALU result and a variable-latency load response.
// Stalls upstream while a load is outstanding and exposes its destination.
// Optional feature macro: WB_LOAD_BYPASS_EN.
//   Defined: load data is written in the cycle after mem_rvalid.
//   Undefined: load data passes through LOAD_WB and is written two cycles after mem_rvalid.
module wb_stage #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic          in_reg_write,
    input  logic          in_reg_dst,
    input  logic          in_mem_to_reg,
    input  logic [DW-1:0] in_alu_result,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          RegWrite,
    output logic [4:0]    WrAddr,
    output logic [DW-1:0] WrBack,
    output logic          pend_valid,
    output logic [4:0]    pend_addr,
    output logic          load_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        LOAD_WB   = 2'd2
    } state_t;

    localparam bit          TO_EN   = (LOAD_TIMEOUT != 0);
    localparam logic [31:0] TO_LAST = (LOAD_TIMEOUT == 0) ? '0 : 32'(LOAD_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_back_q, wr_back_d;
    logic          pend_valid_q, pend_valid_d;
    logic [4:0]    pend_addr_q, pend_addr_d;
    logic          ld_we_q, ld_we_d;
    logic          load_err_q, load_err_d;
    logic [31:0]   cnt_q, cnt_d;
`ifndef WB_LOAD_BYPASS_EN
    logic [DW-1:0] ld_data_q, ld_data_d;
`endif

    logic [4:0] dst;
    logic       unused_instr_bits;

    assign dst               = in_reg_dst ? in_instr[15:11] : in_instr[20:16];
    assign unused_instr_bits = ^{in_instr[31:21], in_instr[10:0]};

    assign in_ready   = (state_q == IDLE);
    assign RegWrite   = reg_write_q;
    assign WrAddr     = wr_addr_q;
    assign WrBack     = wr_back_q;
    assign pend_valid = pend_valid_q;
    assign pend_addr  = pend_addr_q;
    assign load_err   = load_err_q;

    // Next-state and write-port logic; the write port holds unless a write retires.
    always_comb begin
        state_d      = state_q;
        reg_write_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_back_d    = wr_back_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        ld_we_d      = ld_we_q;
        load_err_d   = load_err_q;
        cnt_d        = cnt_q;
`ifndef WB_LOAD_BYPASS_EN
        ld_data_d    = ld_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_mem_to_reg) begin
                        state_d      = WAIT_LOAD;
                        pend_valid_d = 1'b1;
                        pend_addr_d  = dst;
                        ld_we_d      = in_reg_write;
                        cnt_d        = '0;
                    end else if (in_reg_write && (dst != 5'd0)) begin
                        reg_write_d = 1'b1;
                        wr_addr_d   = dst;
                        wr_back_d   = in_alu_result;
                    end
                end
            end
            WAIT_LOAD: begin
                cnt_d = cnt_q + 32'd1;
                // Data arriving on the timeout cycle still wins over the error.
                if (mem_rvalid) begin
                    pend_valid_d = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
                    state_d = IDLE;
                    if (ld_we_q && (pend_addr_q != 5'd0)) begin
                        reg_write_d = 1'b1;
                        wr_addr_d   = pend_addr_q;
                        wr_back_d   = mem_rdata;
                    end
`else
                    state_d   = LOAD_WB;
                    ld_data_d = mem_rdata;
`endif
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    load_err_d   = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
`ifndef WB_LOAD_BYPASS_EN
            LOAD_WB: begin
                state_d = IDLE;
                if (ld_we_q && (pend_addr_q != 5'd0)) begin
                    reg_write_d = 1'b1;
                    wr_addr_d   = pend_addr_q;
                    wr_back_d   = ld_data_q;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset that aborts any in-flight load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            reg_write_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_back_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            ld_we_q      <= 1'b0;
            load_err_q   <= 1'b0;
            cnt_q        <= '0;
`ifndef WB_LOAD_BYPASS_EN
            ld_data_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            reg_write_q  <= reg_write_d;
            wr_addr_q    <= wr_addr_d;
            wr_back_q    <= wr_back_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            ld_we_q      <= ld_we_d;
            load_err_q   <= load_err_d;
            cnt_q        <= cnt_d;
`ifndef WB_LOAD_BYPASS_EN
            ld_data_q    <= ld_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage with randomized ALU/load traffic.
// Honours WB_LOAD_BYPASS_EN to select the expected load write latency.
`timescale 1ns/1ps
module tb_wb_stage;
    localparam int DW = 32;
    localparam int TO = 16;
`ifdef WB_LOAD_BYPASS_EN
    localparam int WB_DLY = 0;
`else
    localparam int WB_DLY = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_instr = '0;
    logic          in_reg_write = 1'b0;
    logic          in_reg_dst = 1'b0;
    logic          in_mem_to_reg = 1'b0;
    logic [DW-1:0] in_alu_result = '0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          RegWrite;
    logic [4:0]    WrAddr;
    logic [DW-1:0] WrBack;
    logic          pend_valid;
    logic [4:0]    pend_addr;
    logic          load_err;

    wb_stage #(.LOAD_TIMEOUT(TO), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_reg_write(in_reg_write), .in_reg_dst(in_reg_dst),
        .in_mem_to_reg(in_mem_to_reg), .in_alu_result(in_alu_result),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .RegWrite(RegWrite), .WrAddr(WrAddr), .WrBack(WrBack),
        .pend_valid(pend_valid), .pend_addr(pend_addr), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            mon_en = 1'b0;
    bit            model_err = 1'b0;
    logic [4:0]    hold_addr = '0;
    logic [DW-1:0] hold_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [4:0] dst_of(input logic [31:0] ins, input logic sel);
        return sel ? ins[15:11] : ins[20:16];
    endfunction

    // Monitor: every cycle either a write is expected now or the port must be quiet and holding.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_cmp++; n_err++;
                $display("FAIL missing_write: got none expected addr %0d at cycle %0d", exp_q[0].addr, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (RegWrite === 1'b1) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(WrAddr), 64'(e.addr));
                    check("wr_back", 64'(WrBack), 64'(e.data));
                    hold_addr = e.addr;
                    hold_data = e.data;
                end else begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write (cycle %0d)", WrAddr, WrBack, cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                n_cmp++; n_err++;
                $display("FAIL missing_write: got RegWrite=%b expected addr %0d (cycle %0d)", RegWrite, exp_q[0].addr, cyc);
                void'(exp_q.pop_front());
            end else begin
                check("regwrite_quiet", 64'(RegWrite), 64'(0));
                check("wr_addr_hold", 64'(WrAddr), 64'(hold_addr));
                check("wr_back_hold", 64'(WrBack), 64'(hold_data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid      = 1'b0;
        in_instr      = $urandom;
        in_reg_write  = 1'($urandom_range(0, 1));
        in_reg_dst    = 1'($urandom_range(0, 1));
        in_mem_to_reg = 1'($urandom_range(0, 1));
        in_alu_result = $urandom;
        mem_rvalid    = 1'b0;
        mem_rdata     = $urandom;
    endtask

    // Upstream noise while the stage is stalled; it must not be accepted.
    task automatic drive_noise();
        drive_idle();
        in_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive_idle();
        repeat (n) step();
        rst = 1'b0;
        hold_addr = '0;
        hold_data = '0;
        model_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            check("load_err_idle", 64'(load_err), 64'(model_err));
            drive_idle();
            step();
        end
    endtask

    task automatic check_ready_idle();
        check("in_ready_idle", 64'(in_ready), 64'(1));
        check("pend_valid_idle", 64'(pend_valid), 64'(0));
        check("load_err", 64'(load_err), 64'(model_err));
    endtask

    task automatic issue_alu(input logic [31:0] ins, input logic sel, input logic we, input logic [DW-1:0] alu);
        exp_t e;
        logic [4:0] d;
        check_ready_idle();
        d = dst_of(ins, sel);
        in_valid      = 1'b1;
        in_instr      = ins;
        in_reg_dst    = sel;
        in_reg_write  = we;
        in_mem_to_reg = 1'b0;
        in_alu_result = alu;
        mem_rvalid    = 1'($urandom_range(0, 1));
        mem_rdata     = $urandom;
        if (we && d != 5'd0) begin
            e.cyc = cyc + 1; e.addr = d; e.data = alu;
            exp_q.push_back(e);
        end
        step();
        drive_idle();
    endtask

    // d in 1..TO: rvalid in wait cycle d; d == 0: never; d > TO: rvalid arrives after the timeout.
    task automatic issue_load(input logic [31:0] ins, input logic sel, input logic we,
                              input logic [DW-1:0] rdata, input int d);
        exp_t e;
        logic [4:0] dst;
        int acc;
        check_ready_idle();
        dst = dst_of(ins, sel);
        in_valid      = 1'b1;
        in_instr      = ins;
        in_reg_dst    = sel;
        in_reg_write  = we;
        in_mem_to_reg = 1'b1;
        in_alu_result = $urandom;
        mem_rvalid    = 1'b0;
        acc = cyc + 1;
        step();
        drive_idle();
        if (d >= 1 && d <= TO) begin
            for (int j = 1; j <= d; j++) begin
                check("in_ready_wait", 64'(in_ready), 64'(0));
                check("pend_valid_wait", 64'(pend_valid), 64'(1));
                check("pend_addr", 64'(pend_addr), 64'(dst));
                drive_noise();
                if (j == d) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                end
                step();
            end
            drive_idle();
            if (we && dst != 5'd0) begin
                e.cyc = acc + d + WB_DLY; e.addr = dst; e.data = rdata;
                exp_q.push_back(e);
            end
`ifndef WB_LOAD_BYPASS_EN
            check("in_ready_load_wb", 64'(in_ready), 64'(0));
            check("pend_valid_load_wb", 64'(pend_valid), 64'(0));
            drive_noise();
            mem_rvalid = 1'b1;
            step();
            drive_idle();
`endif
        end else begin
            for (int j = 1; j <= TO; j++) begin
                check("in_ready_wait", 64'(in_ready), 64'(0));
                check("pend_valid_wait", 64'(pend_valid), 64'(1));
                drive_noise();
                step();
            end
            drive_idle();
            model_err = 1'b1;
            check("load_err_timeout", 64'(load_err), 64'(1));
            check("pend_valid_timeout", 64'(pend_valid), 64'(0));
            check("in_ready_timeout", 64'(in_ready), 64'(1));
            if (d > TO) begin
                for (int j = TO + 1; j < d; j++) step();
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                step();
                drive_idle();
            end
        end
    endtask

    task automatic reset_mid_load();
        check_ready_idle();
        in_valid      = 1'b1;
        in_instr      = 32'h000A_5000;
        in_reg_dst    = 1'b1;
        in_reg_write  = 1'b1;
        in_mem_to_reg = 1'b1;
        step();
        drive_idle();
        step();
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        rst = 1'b0;
        drive_idle();
        hold_addr = '0;
        hold_data = '0;
        model_err = 1'b0;
        check("rst_mid_pend_valid", 64'(pend_valid), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
        check("rst_mid_regwrite", 64'(RegWrite), 64'(0));
        check("rst_mid_load_err", 64'(load_err), 64'(0));
        idle_cycles(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        int r;
        drive_idle();
        do_reset(2);
        check("rst_regwrite", 64'(RegWrite), 64'(0));
        check("rst_wraddr", 64'(WrAddr), 64'(0));
        check("rst_wrback", 64'(WrBack), 64'(0));
        check("rst_pend_valid", 64'(pend_valid), 64'(0));
        check("rst_pend_addr", 64'(pend_addr), 64'(0));
        check("rst_load_err", 64'(load_err), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        mon_en = 1'b1;
        idle_cycles(2);

        issue_alu(32'h0000_2800, 1'b1, 1'b1, 32'hDEAD_BEEF);
        issue_alu(32'h0000_0800, 1'b1, 1'b1, 32'h1111_1111);
        issue_alu(32'h0000_1000, 1'b1, 1'b1, 32'h2222_2222);
        issue_alu(32'h0000_1800, 1'b1, 1'b1, 32'h3333_3333);
        idle_cycles(1);
        issue_load(32'h0009_0000, 1'b0, 1'b1, 32'h1234_5678, 4);
        issue_alu(32'h0000_0000, 1'b1, 1'b1, 32'h5555_AAAA);
        idle_cycles(1);
        issue_load(32'h0003_3000, 1'b0, 1'b1, 32'h0BAD_CAFE, TO);
        idle_cycles(1);
        issue_load(32'h001F_0000, 1'b1, 1'b1, 32'h7777_7777, 3);
        issue_load(32'h0011_0000, 1'b0, 1'b1, 32'hFEED_FACE, TO + 3);
        idle_cycles(2);
        reset_mid_load();

        for (int k = 0; k < 200; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) == 0) ins[20:11] = '0;
            r = $urandom_range(0, 19);
            if (r < 10) begin
                issue_alu(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom);
            end else if (r < 16) begin
                issue_load(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom,
                           ($urandom_range(0, 4) == 0) ? TO : $urandom_range(1, 6));
            end else if (r < 19) begin
                idle_cycles($urandom_range(1, 3));
            end else begin
                issue_load(ins, 1'($urandom_range(0, 1)), 1'b1, $urandom,
                           ($urandom_range(0, 1) == 0) ? 0 : TO + $urandom_range(1, 3));
            end
        end

        idle_cycles(4);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
